// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage and its neighbours.
//   fetch_state_e : instruction-fetch controller states
//   NOP_INST      : canonical no-op (addi x0, x0, 0)
//   RESET_PC      : architectural reset value of the program counter
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus bundle: memory request/response channel and the
// buffered-instruction channel towards decode.
//   master : fetch stage (drives request, drives decode channel)
//   slave  : memory + decode side
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_inst;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic              id_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_inst,
    output id_valid, id_inst, id_pc, id_fault,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_inst,
    input  id_valid, id_inst, id_pc, id_fault,
    output id_ready
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage.
// Issues one memory request per PC value, buffers the returned word and
// hands it to decode; pulses pc_en once for each word decode accepts.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   pc    : current PC from the PC register
//   pc_en : advance-PC strobe, one cycle per decode handshake
//   flush : kill the current fetch or buffered instruction
//   bus   : memory request/response and decode channel (master side)
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  input  logic              flush,
  inst_fetch_if.master      bus
);

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic              id_fault_q, id_fault_d;
  logic              aligned;

  assign aligned = (pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= '0;
      id_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_fault_q <= id_fault_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    id_inst_d          = id_inst_q;
    id_pc_d            = id_pc_q;
    id_fault_d         = id_fault_q;
    bus.imem_req_valid = 1'b0;
    bus.imem_req_addr  = '0;
    bus.id_valid       = 1'b0;
    pc_en              = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        // The request stays visible during a flush: if memory takes it in
        // that cycle the response is already owed and must be drained.
        if (aligned) begin
          bus.imem_req_valid = 1'b1;
          bus.imem_req_addr  = pc;
        end
        if (flush) begin
          if (aligned && bus.imem_req_ready) state_d = DRAIN;
        end else if (!aligned) begin
          id_pc_d    = pc;
          id_inst_d  = NOP_INST;
          id_fault_d = 1'b1;
          state_d    = HOLD;
        end else if (bus.imem_req_ready) begin
          id_pc_d = pc;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (flush) begin
          state_d = bus.imem_resp_valid ? REQ : DRAIN;
        end else if (bus.imem_resp_valid) begin
          id_inst_d  = bus.imem_resp_inst;
          id_fault_d = 1'b0;
          state_d    = HOLD;
        end
      end

      // Swallow the one response still owed by memory; flush is moot here.
      DRAIN: if (bus.imem_resp_valid) state_d = REQ;

      HOLD: begin
        bus.id_valid = 1'b1;
        if (flush) begin
          state_d = REQ;
        end else if (bus.id_ready) begin
          pc_en   = 1'b1;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.id_inst  = id_inst_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_fault = id_fault_q;

  // Memory may only answer while a request is outstanding.
  a_resp_expected: assert property (
    @(posedge clk) disable iff (!rst)
    bus.imem_resp_valid |-> (state_q == WAIT || state_q == DRAIN)
  );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import cpu_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] pc;
  logic              pc_en;
  logic              flush;

  inst_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  inst_fetch #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .NOP_INST(NOP_INST)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pc   (pc),
    .pc_en(pc_en),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: ordered list of words decode is owed.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;

  entry_t      expq[$];
  entry_t      mon_e;
  int unsigned hs_seen  = 0;
  int unsigned hs_exp   = 0;
  int unsigned pen_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (pc_en) begin
        pen_seen++;
        check("pc_en_only_on_handshake", {bus.id_valid, bus.id_ready, flush}, 3'b110);
      end
      if (bus.id_valid && bus.id_ready && !flush) begin
        hs_seen++;
        if (expq.size() == 0) begin
          check("unexpected_handoff", 1, 0);
        end else begin
          mon_e = expq.pop_front();
          check("handoff_pc", bus.id_pc, mon_e.pc);
          check("handoff_inst", bus.id_inst, mon_e.inst);
          check("handoff_fault", bus.id_fault, mon_e.fault);
        end
      end
    end
  end

  task automatic quiet(input string tag);
    @(negedge clk);
    check(tag, {bus.imem_req_valid, bus.id_valid, pc_en}, 3'b000);
    @(posedge clk); #1;
  endtask

  // All ops start and end 1 time unit after a rising edge with the DUT in REQ.
  task automatic issue(input logic [31:0] p, input int unsigned stall);
    pc = p;
    bus.imem_req_ready = 1'b0;
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_req_valid", bus.imem_req_valid, 1);
      check("stall_req_addr", bus.imem_req_addr, p);
      check("stall_id_valid", bus.id_valid, 0);
      @(posedge clk); #1;
    end
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    check("req_valid", bus.imem_req_valid, 1);
    check("req_addr", bus.imem_req_addr, p);
    @(posedge clk); #1;
    bus.imem_req_ready = 1'b0;
  endtask

  task automatic respond(input int unsigned lat, input logic [31:0] inst);
    for (int unsigned i = 1; i < lat; i++) quiet("wait_quiet");
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_inst  = inst;
    @(negedge clk);
    check("resp_cycle_quiet", {bus.imem_req_valid, bus.id_valid}, 2'b00);
    @(posedge clk); #1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_inst  = $urandom;
  endtask

  task automatic consume(input logic [31:0] p, input logic [31:0] inst, input logic fault,
                         input int unsigned hold);
    bus.id_ready = 1'b0;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.id_valid, 1);
      check("hold_pc", bus.id_pc, p);
      check("hold_inst", bus.id_inst, inst);
      check("hold_fault", bus.id_fault, fault);
      check("hold_no_pc_en", pc_en, 0);
      check("hold_no_req", bus.imem_req_valid, 0);
      @(posedge clk); #1;
    end
    bus.id_ready = 1'b1;
    hs_exp++;
    @(negedge clk);
    check("handshake_pc_en", pc_en, 1);
    @(posedge clk); #1;
    bus.id_ready = 1'b0;
  endtask

  task automatic op_normal(input logic [31:0] p, input logic [31:0] inst, input int unsigned stall,
                           input int unsigned lat, input int unsigned hold);
    entry_t e;
    issue(p, stall);
    respond(lat, inst);
    e = '{pc: p, inst: inst, fault: 1'b0};
    expq.push_back(e);
    consume(p, inst, 1'b0, hold);
  endtask

  task automatic op_misaligned(input logic [31:0] p, input int unsigned hold);
    entry_t e;
    pc = p;
    bus.imem_req_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("misaligned_no_req", bus.imem_req_valid, 0);
    @(posedge clk); #1;
    bus.imem_req_ready = 1'b0;
    e = '{pc: p, inst: NOP_INST, fault: 1'b1};
    expq.push_back(e);
    consume(p, NOP_INST, 1'b1, hold);
  endtask

  // Flush while a response is outstanding; the stale word must never surface.
  task automatic op_flush_wait(input logic [31:0] p, input logic [31:0] stale, input int unsigned stall,
                               input int unsigned lat, input int unsigned k, input bit coincide,
                               input bit drain_flush);
    issue(p, stall);
    if (coincide) begin
      for (int unsigned i = 1; i < lat; i++) quiet("fw_wait_quiet");
      flush = 1'b1;
    end else begin
      for (int unsigned i = 0; i < k; i++) quiet("fw_wait_quiet");
      flush = 1'b1;
      quiet("fw_flush_cycle");
      flush = drain_flush;
      for (int unsigned i = k + 2; i < lat; i++) quiet("fw_drain_quiet");
    end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_inst  = stale;
    @(negedge clk);
    check("fw_resp_quiet", {bus.imem_req_valid, bus.id_valid, pc_en}, 3'b000);
    @(posedge clk); #1;
    bus.imem_resp_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("fw_back_to_req", {bus.imem_req_valid, bus.id_valid}, 2'b10);
    @(posedge clk); #1;
  endtask

  task automatic op_flush_hold(input logic [31:0] p, input logic [31:0] inst, input int unsigned lat,
                               input logic rdy);
    entry_t e;
    issue(p, 0);
    respond(lat, inst);
    e = '{pc: p, inst: inst, fault: 1'b0};
    expq.push_back(e);
    bus.id_ready = rdy;
    flush = 1'b1;
    @(negedge clk);
    check("fh_valid", bus.id_valid, 1);
    check("fh_no_pc_en", pc_en, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.id_ready = 1'b0;
    expq.delete();
    @(negedge clk);
    check("fh_valid_dropped", bus.id_valid, 0);
    check("fh_in_req", bus.imem_req_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic op_flush_req(input logic [31:0] p, input int unsigned lat, input logic accept);
    pc = p;
    bus.imem_req_ready = accept;
    flush = 1'b1;
    @(negedge clk);
    check("fr_req_valid", bus.imem_req_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.imem_req_ready = 1'b0;
    if (accept) respond(lat, $urandom);
    @(negedge clk);
    check("fr_in_req", {bus.imem_req_valid, bus.id_valid}, 2'b10);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc_en"}, pc_en, 0);
    check({tag, "_req_valid"}, bus.imem_req_valid, 0);
    check({tag, "_id_valid"}, bus.id_valid, 0);
    check({tag, "_id_fault"}, bus.id_fault, 0);
    check({tag, "_id_inst"}, bus.id_inst, NOP_INST);
    check({tag, "_id_pc"}, bus.id_pc, 0);
    check({tag, "_req_addr"}, bus.imem_req_addr, 0);
  endtask

  // Deassert reset away from the edge, then walk through the IDLE cycle.
  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_quiet", {bus.imem_req_valid, bus.id_valid, pc_en}, 3'b000);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_aligned();
    logic [31:0] v;
    v = $urandom;
    return {v[31:2], 2'b00};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pc                  = RESET_PC;
    flush               = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_inst  = '0;
    bus.id_ready        = 1'b0;
    #1 rst = 1'b0;
    #2 check_reset_values("reset");
    release_reset();

    op_normal(RESET_PC, 32'h0050_0093, 0, 2, 0);
    op_normal(RESET_PC + 32'd4, 32'h0000_0113, 4, 1, 5);
    op_flush_wait(RESET_PC + 32'd8, 32'hDEAD_BEEF, 0, 3, 0, 1'b0, 1'b0);
    op_flush_hold(RESET_PC + 32'd8, 32'h0020_8193, 1, 1'b1);
    op_misaligned(RESET_PC + 32'd2, 2);
    op_flush_req(RESET_PC + 32'd12, 2, 1'b1);
    op_flush_req(RESET_PC + 32'd12, 1, 1'b0);

    for (int unsigned n = 0; n < 200; n++) begin
      int unsigned sel;
      int unsigned lat;
      sel = $urandom_range(0, 9);
      lat = $urandom_range(2, 5);
      case (sel)
        5: op_misaligned(rand_aligned() | 32'($urandom_range(1, 3)), $urandom_range(0, 3));
        6: op_flush_wait(rand_aligned(), $urandom, $urandom_range(0, 2), lat,
                         $urandom_range(0, lat - 2), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
        7: op_flush_hold(rand_aligned(), $urandom, lat, 1'($urandom_range(0, 1)));
        8: op_flush_req(rand_aligned(), lat, 1'($urandom_range(0, 1)));
        9: op_normal(rand_aligned(), $urandom, $urandom_range(3, 8), lat, $urandom_range(3, 8));
        default: op_normal(rand_aligned(), $urandom, $urandom_range(0, 2), $urandom_range(1, 4),
                           $urandom_range(0, 2));
      endcase
    end

    // Reset while waiting on memory, with a stale fault flag in the buffer.
    op_misaligned(RESET_PC + 32'd1, 0);
    issue(RESET_PC + 32'd16, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1 check_reset_values("rst_wait");
    release_reset();

    // Reset in the middle of a decode handshake.
    issue(RESET_PC + 32'd20, 0);
    respond(2, 32'h1234_5678);
    bus.id_ready = 1'b1;
    #1 check("rst_hold_pc_en_before", pc_en, 1);
    check("rst_hold_valid_before", bus.id_valid, 1);
    #1 rst = 1'b0;
    #1 check_reset_values("rst_hold");
    bus.id_ready = 1'b0;
    release_reset();

    op_normal(RESET_PC, 32'h0050_0093, 1, 2, 1);

    check("pc_en_count", pen_seen, hs_exp);
    check("handoff_count", hs_seen, hs_exp);
    check("owed_words_left", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
